regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/wb_fifo2.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and write-entry type for the regfile write-back arbiter
package regfile_pkg;

  localparam int REG_ADDR_W    = 4;
  localparam int DATA_W        = 32;
  localparam int NUM_REGS      = 16;
  localparam int WB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] regIdx;
    logic [DATA_W-1:0]     data;
  } wbEntry_t;

  function automatic logic [NUM_REGS-1:0] decodeReg(input logic [REG_ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] oneHot;
    oneHot      = '0;
    oneHot[idx] = 1'b1;
    return oneHot;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry write-back FIFO with per-slot visibility for the pending mask
module wb_fifo2
  import regfile_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  wbEntry_t                            pushEntry,
  input  logic                                pop,
  output wbEntry_t                            head,
  output logic [1:0]                          count,
  output logic [WB_FIFO_DEPTH-1:0]            entryValid,
  output logic [WB_FIFO_DEPTH*REG_ADDR_W-1:0] entryReg
);

  localparam logic [1:0] FULL = 2'(WB_FIFO_DEPTH);

  wbEntry_t slots [WB_FIFO_DEPTH];
  logic     rdPtr;
  logic     wrPtr;
  logic     doPush;
  logic     doPop;

  assign doPush = push && (count != FULL);
  assign doPop  = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
    end else begin
      if (doPush) wrPtr <= ~wrPtr;
      if (doPop)  rdPtr <= ~rdPtr;
      case ({doPush, doPop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity comes from count and pointers.
  always_ff @(posedge clk) begin
    if (rst && doPush) slots[wrPtr] <= pushEntry;
  end

  assign head = slots[rdPtr];

  for (genvar i = 0; i < WB_FIFO_DEPTH; i++) begin : gSlot
    assign entryValid[i] = (count == FULL) || ((count == 2'd1) && (rdPtr == 1'(i)));
    assign entryReg[i*REG_ADDR_W +: REG_ADDR_W] = slots[i].regIdx;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter merging two write-back queues onto one regfile write port
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  wr_src,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam logic [1:0] FULL = 2'(WB_FIFO_DEPTH);

  wbEntry_t                            head0, head1, granted;
  logic [1:0]                          count0, count1;
  logic [WB_FIFO_DEPTH-1:0]            valid0, valid1;
  logic [WB_FIFO_DEPTH*REG_ADDR_W-1:0] regs0, regs1;
  logic                                nonEmpty0, nonEmpty1;
  logic                                anyReq, grant1, pop0, pop1;
  logic                                lastGrant;

  assign req0_ready = (count0 != FULL);
  assign req1_ready = (count1 != FULL);

  wb_fifo2 uFifo0 (
    .clk        (clk),
    .rst        (rst),
    .push       (req0_valid && req0_ready),
    .pushEntry  ('{regIdx: req0_reg, data: req0_data}),
    .pop        (pop0),
    .head       (head0),
    .count      (count0),
    .entryValid (valid0),
    .entryReg   (regs0)
  );

  wb_fifo2 uFifo1 (
    .clk        (clk),
    .rst        (rst),
    .push       (req1_valid && req1_ready),
    .pushEntry  ('{regIdx: req1_reg, data: req1_data}),
    .pop        (pop1),
    .head       (head1),
    .count      (count1),
    .entryValid (valid1),
    .entryReg   (regs1)
  );

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    nonEmpty0 = (count0 != 2'd0);
    nonEmpty1 = (count1 != 2'd0);
    anyReq    = nonEmpty0 || nonEmpty1;
    grant1    = nonEmpty1 && (!nonEmpty0 || !lastGrant);
    pop0      = nonEmpty0 && !grant1;
    pop1      = grant1;
    granted   = grant1 ? head1 : head0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      wr_src    <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      wr_en <= anyReq;
      if (anyReq) begin
        wr_reg    <= granted.regIdx;
        wr_data   <= granted.data;
        wr_src    <= grant1;
        lastGrant <= grant1;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      if (valid0[i]) pending_mask |= decodeReg(regs0[i*REG_ADDR_W +: REG_ADDR_W]);
      if (valid1[i]) pending_mask |= decodeReg(regs1[i*REG_ADDR_W +: REG_ADDR_W]);
    end
    if (wr_en) pending_mask |= decodeReg(wr_reg);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed table, corner sequences and random model check of regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_reg = '0, req1_reg = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        wr_en, wr_src;
  logic [3:0]  wr_reg;
  logic [31:0] wr_data;
  logic [15:0] pending_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_reg     (req0_reg),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_reg     (req1_reg),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .wr_en        (wr_en),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .wr_src       (wr_src),
    .pending_mask (pending_mask)
  );

  typedef struct {
    logic        rstN;
    logic        v0;
    logic [3:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [3:0]  r1;
    logic [31:0] d1;
    logic        en;
    logic [3:0]  wreg;
    logic [31:0] wdata;
    logic        src;
    logic [15:0] mask;
    logic        rdy0;
    logic        rdy1;
  } vec_t;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
  } ent_t;

  vec_t tbl[$];

  ent_t        mq0[$];
  ent_t        mq1[$];
  logic        mLast;
  logic        mEn, mSrc;
  logic [3:0]  mReg;
  logic [31:0] mData;

  function automatic vec_t mk(logic rs, logic v0, logic [3:0] r0, logic [31:0] d0,
                              logic v1, logic [3:0] r1, logic [31:0] d1,
                              logic en, logic [3:0] wreg, logic [31:0] wdata, logic src,
                              logic [15:0] mask, logic rdy0, logic rdy1);
    vec_t v;
    v.rstN = rs; v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.en = en; v.wreg = wreg; v.wdata = wdata; v.src = src; v.mask = mask;
    v.rdy0 = rdy0; v.rdy1 = rdy1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic rs, input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] r1, input logic [31:0] d1);
    rst = rs; req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
  endtask

  // Reference: two bounded queues, a round-robin bit and a registered output slot.
  task automatic modelStep(input logic rs, input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                           input logic v1, input logic [3:0] r1, input logic [31:0] d1);
    bit acc0, acc1, has0, has1, pick1;
    ent_t e;
    if (!rs) begin
      mq0.delete(); mq1.delete();
      mLast = 1'b1; mEn = 1'b0; mReg = '0; mData = '0; mSrc = 1'b0;
      return;
    end
    acc0 = v0 && (mq0.size() < 2);
    acc1 = v1 && (mq1.size() < 2);
    has0 = mq0.size() > 0;
    has1 = mq1.size() > 0;
    mEn = has0 || has1;
    if (has0 || has1) begin
      if (has0 && has1) pick1 = (mLast == 1'b0);
      else              pick1 = has1;
      e = pick1 ? mq1.pop_front() : mq0.pop_front();
      mReg = e.r; mData = e.d; mSrc = pick1; mLast = pick1;
    end
    if (acc0) mq0.push_back('{r: r0, d: d0});
    if (acc1) mq1.push_back('{r: r1, d: d1});
  endtask

  function automatic logic [15:0] modelMask();
    logic [15:0] m = '0;
    foreach (mq0[i]) m[mq0[i].r] = 1'b1;
    foreach (mq1[i]) m[mq1[i].r] = 1'b1;
    if (mEn) m[mReg] = 1'b1;
    return m;
  endfunction

  task automatic checkModel(input string tag);
    chk({tag, "_rdy0"}, 32'(req0_ready), 32'(mq0.size() < 2));
    chk({tag, "_rdy1"}, 32'(req1_ready), 32'(mq1.size() < 2));
    chk({tag, "_en"},   32'(wr_en),      32'(mEn));
    chk({tag, "_reg"},  32'(wr_reg),     32'(mReg));
    chk({tag, "_data"}, wr_data,         mData);
    chk({tag, "_src"},  32'(wr_src),     32'(mSrc));
    chk({tag, "_mask"}, 32'(pending_mask), 32'(modelMask()));
  endtask

  task automatic drive(input string tag, input logic rs, input logic v0, input logic [3:0] r0,
                       input logic [31:0] d0, input logic v1, input logic [3:0] r1, input logic [31:0] d1);
    setIn(rs, v0, r0, d0, v1, r1, d1);
    modelStep(rs, v0, r0, d0, v1, r1, d1);
    @(posedge clk); #1;
    checkModel(tag);
  endtask

  initial begin
    logic [31:0] seen1[$];
    logic [31:0] want1[$];

    // Directed table: reset, single write, same-register contention, alternation, mid-run reset.
    tbl.push_back(mk(0, 1,7,32'h55,       1,8,32'h66,  0,0,32'h0,        0,16'h0000,1,1));
    tbl.push_back(mk(1, 1,3,32'hDEADBEEF, 0,0,32'h0,   0,0,32'h0,        0,16'h0008,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   1,3,32'hDEADBEEF, 0,16'h0008,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   0,3,32'hDEADBEEF, 0,16'h0000,1,1));
    tbl.push_back(mk(0, 0,0,32'h0,        0,0,32'h0,   0,0,32'h0,        0,16'h0000,1,1));
    tbl.push_back(mk(1, 1,5,32'h11,       1,5,32'h22,  0,0,32'h0,        0,16'h0020,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   1,5,32'h11,       0,16'h0020,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   1,5,32'h22,       1,16'h0020,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   0,5,32'h22,       1,16'h0000,1,1));
    tbl.push_back(mk(1, 1,1,32'hA0,       1,2,32'hB0,  0,5,32'h22,       1,16'h0006,1,1));
    tbl.push_back(mk(1, 1,1,32'hA0,       1,2,32'hB0,  1,1,32'hA0,       0,16'h0006,1,0));
    tbl.push_back(mk(1, 1,1,32'hA0,       1,2,32'hB0,  1,2,32'hB0,       1,16'h0006,0,1));
    tbl.push_back(mk(1, 1,1,32'hA0,       1,2,32'hB0,  1,1,32'hA0,       0,16'h0006,1,0));
    tbl.push_back(mk(1, 1,1,32'hA0,       1,2,32'hB0,  1,2,32'hB0,       1,16'h0006,0,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   1,1,32'hA0,       0,16'h0006,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   1,2,32'hB0,       1,16'h0006,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   1,1,32'hA0,       0,16'h0002,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   0,1,32'hA0,       0,16'h0000,1,1));
    tbl.push_back(mk(1, 1,9,32'h99,       1,10,32'hAA, 0,1,32'hA0,       0,16'h0600,1,1));
    tbl.push_back(mk(1, 1,9,32'h99,       1,10,32'hAA, 1,10,32'hAA,      1,16'h0600,0,1));
    tbl.push_back(mk(0, 1,9,32'h99,       1,10,32'hAA, 0,0,32'h0,        0,16'h0000,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   0,0,32'h0,        0,16'h0000,1,1));
    tbl.push_back(mk(1, 0,0,32'h0,        0,0,32'h0,   0,0,32'h0,        0,16'h0000,1,1));

    for (int i = 0; i < tbl.size(); i++) begin
      setIn(tbl[i].rstN, tbl[i].v0, tbl[i].r0, tbl[i].d0, tbl[i].v1, tbl[i].r1, tbl[i].d1);
      @(posedge clk); #1;
      chk($sformatf("row%0d_en", i),   32'(wr_en),        32'(tbl[i].en));
      chk($sformatf("row%0d_reg", i),  32'(wr_reg),       32'(tbl[i].wreg));
      chk($sformatf("row%0d_data", i), wr_data,           tbl[i].wdata);
      chk($sformatf("row%0d_src", i),  32'(wr_src),       32'(tbl[i].src));
      chk($sformatf("row%0d_mask", i), 32'(pending_mask), 32'(tbl[i].mask));
      chk($sformatf("row%0d_rdy0", i), 32'(req0_ready),   32'(tbl[i].rdy0));
      chk($sformatf("row%0d_rdy1", i), 32'(req1_ready),   32'(tbl[i].rdy1));
    end

    // req1 offers three entries against a steady req0 stream; the third must wait for a slot.
    want1 = '{32'h601, 32'h602, 32'h603};
    drive("bp_rst", 0, 0,0,0, 0,0,0);
    drive("bp_c1", 1, 1,4,32'h400, 1,6,32'h601);
    drive("bp_c2", 1, 1,4,32'h401, 1,6,32'h602);
    chk("bp_full_rdy1", 32'(req1_ready), 32'd0);
    drive("bp_c3", 1, 1,4,32'h402, 1,6,32'h603);
    if (wr_en && wr_src) seen1.push_back(wr_data);
    chk("bp_slot_rdy1", 32'(req1_ready), 32'd1);
    drive("bp_c4", 1, 1,4,32'h403, 1,6,32'h603);
    if (wr_en && wr_src) seen1.push_back(wr_data);
    for (int k = 0; k < 8; k++) begin
      drive("bp_drain", 1, 0,0,0, 0,0,0);
      if (wr_en && wr_src) seen1.push_back(wr_data);
    end
    chk("bp_count", 32'(seen1.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), (k < seen1.size()) ? seen1[k] : 32'hFFFF_FFFF, want1[k]);

    // Random traffic with occasional reset, every cycle compared to the reference.
    for (int n = 0; n < 3000; n++) begin
      drive("rnd", ($urandom_range(0, 199) != 0),
            ($urandom_range(0, 3) != 0), 4'($urandom), $urandom,
            ($urandom_range(0, 3) != 0), 4'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
